// File: rtl/bus_dest_ctrl.sv
// ============================================================================
// bus_dest_ctrl: routes one bus byte per request to a register strobe or a handshaked memory write. Rev 1.0
// ============================================================================
`default_nettype none

module bus_dest_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] dest_sel,
  input  logic [2:0] reg_addr,
  input  logic [7:0] bus_data,
  input  logic [7:0] mar_data,
  output logic       gpr_we,
  output logic [2:0] gpr_waddr,
  output logic       pc_load,
  output logic       ir_load,
  output logic       mar_load,
  output logic [7:0] load_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wr_data,
  input  logic       mem_ack,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] c_dest_gpr = 3'd0;
  localparam logic [2:0] c_dest_pc  = 3'd1;
  localparam logic [2:0] c_dest_ir  = 3'd2;
  localparam logic [2:0] c_dest_mar = 3'd3;
  localparam logic [2:0] c_dest_mem = 3'd4;
  localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_dest;
  logic [2:0] r_gpr_waddr;
  logic [7:0] r_load_data;
  logic [7:0] r_mem_addr;
  logic [7:0] r_mem_data;
  logic [7:0] r_wait_cnt;
  logic       w_accept;
  logic       w_is_reg_dest;

  assign w_accept      = (r_state == ST_IDLE) && req_valid;
  assign w_is_reg_dest = (dest_sel == c_dest_gpr) || (dest_sel == c_dest_pc) ||
                         (dest_sel == c_dest_ir)  || (dest_sel == c_dest_mar);

  // Each data output only changes when a request for its own destination is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_dest      <= '0;
      r_gpr_waddr <= '0;
      r_load_data <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dest <= dest_sel;
        if (w_is_reg_dest) r_load_data <= bus_data;
        if (dest_sel == c_dest_gpr) r_gpr_waddr <= reg_addr;
        if (dest_sel == c_dest_mem) begin
          r_mem_addr <= mar_data;
          r_mem_data <= bus_data;
        end
      end
      if (r_state == ST_MEM_WAIT) r_wait_cnt <= r_wait_cnt + 8'd1;
      else                        r_wait_cnt <= '0;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    gpr_we    = 1'b0;
    pc_load   = 1'b0;
    ir_load   = 1'b0;
    mar_load  = 1'b0;
    mem_wr_en = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_is_reg_dest)                w_next = ST_LOAD;
          else if (dest_sel == c_dest_mem) w_next = ST_MEM_WAIT;
          else                              w_next = ST_FAULT;
        end
      end
      ST_LOAD: begin
        done = 1'b1;
        case (r_dest)
          c_dest_gpr: gpr_we   = 1'b1;
          c_dest_pc:  pc_load  = 1'b1;
          c_dest_ir:  ir_load  = 1'b1;
          default:    mar_load = 1'b1;
        endcase
        w_next = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        mem_wr_en = 1'b1;
        // An ack on the final count still wins over the timeout.
        if (mem_ack) begin
          done   = 1'b1;
          w_next = ST_IDLE;
        end else if (r_wait_cnt == c_wait_last) begin
          err    = 1'b1;
          w_next = ST_IDLE;
        end
      end
      ST_FAULT: begin
        err    = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign gpr_waddr   = r_gpr_waddr;
  assign load_data   = r_load_data;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_data;

endmodule

`default_nettype wire

// File: tb/tb_bus_dest_ctrl.sv
// ============================================================================
// tb_bus_dest_ctrl: directed and randomized self-checking bench for bus_dest_ctrl. Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_dest_ctrl;

  localparam int T = 4;
  localparam logic [2:0] D_GPR = 3'd0, D_PC = 3'd1, D_IR = 3'd2, D_MAR = 3'd3, D_MEM = 3'd4;
  // Control view: {req_ready, gpr_we, pc_load, ir_load, mar_load, mem_wr_en, done, err}
  localparam logic [7:0] V_IDLE = 8'h80, V_MEM = 8'h04, V_DONE = 8'h02, V_ERR = 8'h01;

  logic       clk = 1'b0;
  logic       reset, req_valid, req_ready, mem_ack;
  logic [2:0] dest_sel, reg_addr, gpr_waddr;
  logic [7:0] bus_data, mar_data, load_data, mem_addr, mem_wr_data;
  logic       gpr_we, pc_load, ir_load, mar_load, mem_wr_en, done, err;

  int pass_cnt = 0;
  int total_cnt = 0;

  bus_dest_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .dest_sel(dest_sel), .reg_addr(reg_addr), .bus_data(bus_data), .mar_data(mar_data),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .pc_load(pc_load), .ir_load(ir_load),
    .mar_load(mar_load), .load_data(load_data), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_ack(mem_ack), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {req_ready, gpr_we, pc_load, ir_load, mar_load, mem_wr_en, done, err};
  endfunction

  function automatic logic [7:0] strobe_of(input logic [2:0] d);
    logic [7:0] b;
    b = 8'h40;
    return b >> d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] d, input logic [2:0] ra, input logic [7:0] bd, input logic [7:0] md);
    req_valid = 1'b1;
    dest_sel  = d;
    reg_addr  = ra;
    bus_data  = bd;
    mar_data  = md;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (obs() !== V_IDLE) $display("FAIL reset_ctl got %b want %b", obs(), V_IDLE); else pass_cnt++;
    total_cnt++; if ({load_data, gpr_waddr} !== 11'd0) $display("FAIL reset_load got %h/%h want 0/0", load_data, gpr_waddr); else pass_cnt++;
    total_cnt++; if ({mem_addr, mem_wr_data} !== 16'd0) $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_wr_data); else pass_cnt++;
    step();
    reset = 1'b0;
  endtask

  task automatic test_pc();
    drive(D_PC, 3'd0, 8'h3C, 8'h00);
    @(negedge clk);
    total_cnt++; if (obs() !== V_IDLE) $display("FAIL pc_accept got %b want %b", obs(), V_IDLE); else pass_cnt++;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (obs() !== (strobe_of(D_PC) | V_DONE)) $display("FAIL pc_strobe got %b want %b", obs(), strobe_of(D_PC) | V_DONE); else pass_cnt++;
    total_cnt++; if (load_data !== 8'h3C) $display("FAIL pc_data got %h want 3c", load_data); else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++; if (obs() !== V_IDLE) $display("FAIL pc_ready_again got %b want %b", obs(), V_IDLE); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive(D_GPR, 3'd5, 8'hA7, 8'h00);
    step();
    drive(D_IR, 3'd2, 8'h11, 8'h00);
    @(negedge clk);
    total_cnt++; if (obs() !== (strobe_of(D_GPR) | V_DONE)) $display("FAIL b2b_gpr got %b want %b", obs(), strobe_of(D_GPR) | V_DONE); else pass_cnt++;
    total_cnt++; if ({gpr_waddr, load_data} !== {3'd5, 8'hA7}) $display("FAIL b2b_gpr_data got %0d/%h want 5/a7", gpr_waddr, load_data); else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++; if (obs() !== V_IDLE) $display("FAIL b2b_gap got %b want %b", obs(), V_IDLE); else pass_cnt++;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (obs() !== (strobe_of(D_IR) | V_DONE)) $display("FAIL b2b_ir got %b want %b", obs(), strobe_of(D_IR) | V_DONE); else pass_cnt++;
    total_cnt++; if ({gpr_waddr, load_data} !== {3'd5, 8'h11}) $display("FAIL b2b_ir_data got %0d/%h want 5/11", gpr_waddr, load_data); else pass_cnt++;
    step();
  endtask

  // ack_at = 0 means memory never acknowledges.
  task automatic test_mem(input int ack_at, input int cycles, input string name);
    logic [7:0] want;
    drive(D_MEM, 3'd0, 8'h5A, 8'h80);
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= cycles; i++) begin
      mem_ack = (i == ack_at);
      want = V_MEM | ((i == ack_at) ? V_DONE : (i == cycles ? V_ERR : 8'h00));
      @(negedge clk);
      total_cnt++; if (obs() !== want) $display("FAIL %s_c%0d got %b want %b", name, i, obs(), want); else pass_cnt++;
      total_cnt++; if ({mem_addr, mem_wr_data} !== 16'h805A) $display("FAIL %s_data_c%0d got %h/%h want 80/5a", name, i, mem_addr, mem_wr_data); else pass_cnt++;
      step();
    end
    mem_ack = 1'b0;
    @(negedge clk);
    total_cnt++; if (obs() !== V_IDLE) $display("FAIL %s_after got %b want %b", name, obs(), V_IDLE); else pass_cnt++;
  endtask

  task automatic test_invalid();
    drive(3'd6, 3'd1, 8'hEE, 8'h22);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (obs() !== V_ERR) $display("FAIL invalid_err got %b want %b", obs(), V_ERR); else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++; if (obs() !== V_IDLE) $display("FAIL invalid_idle got %b want %b", obs(), V_IDLE); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive(D_MEM, 3'd0, 8'h44, 8'h33);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (obs() !== V_MEM) $display("FAIL rmid_wait got %b want %b", obs(), V_MEM); else pass_cnt++;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (obs() !== V_IDLE) $display("FAIL rmid_idle got %b want %b", obs(), V_IDLE); else pass_cnt++;
    total_cnt++; if ({mem_addr, mem_wr_data} !== 16'd0) $display("FAIL rmid_mem got %h/%h want 0/0", mem_addr, mem_wr_data); else pass_cnt++;
    drive(D_MAR, 3'd0, 8'h07, 8'h00);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (obs() !== (strobe_of(D_MAR) | V_DONE)) $display("FAIL rmid_mar got %b want %b", obs(), strobe_of(D_MAR) | V_DONE); else pass_cnt++;
    total_cnt++; if (load_data !== 8'h07) $display("FAIL rmid_mar_data got %h want 07", load_data); else pass_cnt++;
    step();
  endtask

  // Reference: each request yields a list of per-cycle control views derived from its
  // destination and the cycle at which memory acknowledges.
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [2:0] d, ra;
    logic [7:0] bd, md;
    int k, n;
    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(0, 10);
      d = (n > 7) ? D_MEM : 3'(n);
      ra = 3'($urandom); bd = 8'($urandom); md = 8'($urandom);
      k = $urandom_range(1, T + 2);
      exp_q.delete();
      if (d <= D_MAR) exp_q.push_back(strobe_of(d) | V_DONE);
      else if (d == D_MEM) begin
        n = (k < T) ? k : T;
        for (int i = 1; i <= n; i++)
          exp_q.push_back(V_MEM | ((i < n) ? 8'h00 : ((k <= T) ? V_DONE : V_ERR)));
      end else exp_q.push_back(V_ERR);

      drive(d, ra, bd, md);
      mem_ack = 1'($urandom);
      @(negedge clk);
      total_cnt++; if (obs() !== V_IDLE) $display("FAIL rnd%0d_accept got %b want %b", t, obs(), V_IDLE); else pass_cnt++;
      step();
      for (int i = 0; i < exp_q.size(); i++) begin
        drive(3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
        req_valid = 1'($urandom);
        mem_ack = (d == D_MEM) ? (i + 1 == k) : 1'($urandom);
        @(negedge clk);
        total_cnt++; if (obs() !== exp_q[i]) $display("FAIL rnd%0d_c%0d dest %0d k %0d got %b want %b", t, i + 1, d, k, obs(), exp_q[i]); else pass_cnt++;
        if (d <= D_MAR) begin
          total_cnt++; if (load_data !== bd) $display("FAIL rnd%0d_load got %h want %h", t, load_data, bd); else pass_cnt++;
        end
        if (d == D_GPR) begin
          total_cnt++; if (gpr_waddr !== ra) $display("FAIL rnd%0d_waddr got %0d want %0d", t, gpr_waddr, ra); else pass_cnt++;
        end
        if (d == D_MEM) begin
          total_cnt++; if ({mem_addr, mem_wr_data} !== {md, bd}) $display("FAIL rnd%0d_mem got %h/%h want %h/%h", t, mem_addr, mem_wr_data, md, bd); else pass_cnt++;
        end
        step();
      end
      req_valid = 1'b0;
      mem_ack = 1'b0;
    end
    @(negedge clk);
    total_cnt++; if (obs() !== V_IDLE) $display("FAIL rnd_final got %b want %b", obs(), V_IDLE); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; mem_ack = 1'b0;
    dest_sel = '0; reg_addr = '0; bus_data = '0; mar_data = '0;
    step();
    step();
    test_reset();
    test_pc();
    test_back_to_back();
    test_mem(3, 3, "mem_ack");
    test_mem(0, T, "mem_timeout");
    test_mem(T, T, "mem_ack_last");
    test_invalid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_dest_ctrl.md
# bus_dest_ctrl

Bus destination controller: the receiving end of the 8-bit internal data bus, complementary to the bus source mux. It accepts one transfer request at a time, with a destination code and the bus byte. It then issues the matching single-cycle load strobe (general register file, PC, IR, MAR) or runs a handshaked write to memory at the address held in MAR. It sits between the control unit and the datapath registers and memory.

## Interface
Parameters:
- MEM_TIMEOUT, default 15: maximum cycles mem_wr_en is held waiting for mem_ack before the write is abandoned (range 1..255).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  transfer request present
- req_ready  out  1  controller can accept a request
- dest_sel  in  3  destination code, shared selector defines: GENERAL_REGISTERS, PC, IR, MAR, MEMORY
- reg_addr  in  3  general register index; used only for GENERAL_REGISTERS
- bus_data  in  8  byte on the bus
- mar_data  in  8  current MAR contents; memory write address
- gpr_we  out  1  register file write strobe
- gpr_waddr  out  3  register file write index
- pc_load, ir_load, mar_load  out  1 each  load strobes
- load_data  out  8  captured byte for all register destinations
- mem_wr_en  out  1  memory write request
- mem_addr  out  8  memory write address
- mem_wr_data  out  8  memory write data
- mem_ack  in  1  memory write accepted
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on invalid destination or memory timeout

## Operation
- States: IDLE, LOAD, MEM_WAIT, FAULT.
- IDLE: req_ready=1. When req_valid=1, the controller captures dest_sel, reg_addr and bus_data. For MEMORY it also captures mar_data. Next state:
  - LOAD for GENERAL_REGISTERS, PC, IR, MAR
  - MEM_WAIT for MEMORY
  - FAULT for any other code
- LOAD: exactly one of gpr_we, pc_load, ir_load, mar_load is high for one cycle. load_data and gpr_waddr hold the captured values. done=1. Next state is IDLE.
- MEM_WAIT: mem_wr_en=1. mem_addr and mem_wr_data hold the captured values. An 8-bit wait counter starts at 0 and increments each cycle.
  - mem_ack=1 sampled: done=1 in that cycle, mem_wr_en drops the next cycle, state returns to IDLE.
  - Counter reaches MEM_TIMEOUT-1 without ack: err=1 in that cycle, then IDLE. No retry.
- FAULT: err=1 for one cycle, no strobes, then IDLE.
- req_ready=0 in every state except IDLE. Request inputs are ignored while req_ready=0.
- In all other cycles, every strobe, done and err is 0. Data outputs hold their last captured values.
- mem_ack outside MEM_WAIT is ignored.

## Timing
- Reset values: state IDLE, req_ready=1, all strobes 0, mem_wr_en=0, done=0, err=0, load_data=0, gpr_waddr=0, mem_addr=0, mem_wr_data=0, wait counter 0.
- Register destination:
  - Accept at cycle N; strobe and done at N+1; req_ready=1 again at N+2.
  - Throughput is one transfer per 2 cycles.
- Memory destination:
  - Accept at N; mem_wr_en rises at N+1.
  - If mem_ack arrives in cycle N+k (k≥1), done pulses at N+k and mem_wr_en falls at N+k+1.
  - Fastest case (ack at N+1): 2-cycle occupancy.
- Timeout: err at cycle N+MEM_TIMEOUT; mem_wr_en low from N+MEM_TIMEOUT+1.
- mem_ack arriving in the same cycle as the final timeout count counts as success: done=1, err=0.
- Reset asserted mid-operation: the controller returns to IDLE on the next edge. mem_wr_en and all strobes drop immediately, with no done or err pulse. The interrupted transfer is lost.
- done and err are never high in the same cycle.

## Test plan
- Reset, then request PC with bus_data=0x3C: pc_load=1 and load_data=0x3C exactly one cycle after acceptance, done=1 in the same cycle, req_ready low for that one cycle only.
- Request GENERAL_REGISTERS, reg_addr=5, bus_data=0xA7, back-to-back with IR, bus_data=0x11:
  - gpr_we=1, gpr_waddr=5, load_data=0xA7.
  - Two cycles later ir_load=1, load_data=0x11.
  - No overlap between the two strobes.
- Request MEMORY, mar_data=0x80, bus_data=0x5A, mem_ack after 3 cycles:
  - mem_wr_en high for 3 cycles with mem_addr=0x80, mem_wr_data=0x5A.
  - done on the ack cycle, no err.
- MEMORY with MEM_TIMEOUT=4 and no ack: mem_wr_en high 4 cycles, err=1 on the 4th, done never asserted, req_ready=1 the cycle after.
- Invalid dest_sel (an unused code): no strobe, no mem_wr_en, err=1 one cycle after acceptance, then IDLE.
- Reset asserted during MEM_WAIT: mem_wr_en=0 and req_ready=1 on the next cycle, no done or err. A subsequent MAR request with 0x07 completes normally.
